// File: rtl/aqed_fc_multichan_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aqed_fc_multichan_monitor_pkg
// Description : Shared types and constants for the multi-channel A-QED
//               functional-consistency monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package aqed_fc_multichan_monitor_pkg;

  // Default width of the per-channel write/read index counters.
  localparam int AQED_CNT_W = 16;

  // Consistency-check FSM states.
  typedef enum logic [2:0] {
    AQED_IDLE = 3'd0,
    AQED_ORIG = 3'd1,
    AQED_WAIT = 3'd2,
    AQED_DONE = 3'd3
  } aqed_st_t;

  // Plain-vector encodings of the same states, used for the state register
  // so that existing debug tooling sees a bare 3-bit code.
  localparam logic [2:0] ST_IDLE = AQED_IDLE;
  localparam logic [2:0] ST_ORIG = AQED_ORIG;
  localparam logic [2:0] ST_WAIT = AQED_WAIT;
  localparam logic [2:0] ST_DONE = AQED_DONE;

endpackage
`default_nettype wire

// File: rtl/aqed_fc_multichan_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : aqed_fc_multichan_monitor_if
// Description : Bus bundle between stimulus/memory side and the monitor.
//               master : stimulus + memory models (drive requests, read data)
//               slave  : the monitor (drives ready, write/read strobes)
//   in_data/in_valid/in_ch/orig_req/dup_req : write stimulus
//   in_ready                                : write accepted if in_valid
//   rd_req                                  : per-channel read request
//   dut_wdata/dut_wen/dut_ren               : strobes toward memory cores
//   dut_rdata/dut_rvalid                    : read return from memory cores
// Revision    : 1.0 - initial release
// ============================================================================
interface aqed_fc_multichan_monitor_if #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [DATA_W-1:0]        in_data;
  logic                     in_valid;
  logic [CH_W-1:0]          in_ch;
  logic                     orig_req;
  logic                     dup_req;
  logic                     in_ready;
  logic [NUM_CH-1:0]        rd_req;
  logic [DATA_W-1:0]        dut_wdata;
  logic [NUM_CH-1:0]        dut_wen;
  logic [NUM_CH-1:0]        dut_ren;
  logic [NUM_CH*DATA_W-1:0] dut_rdata;
  logic [NUM_CH-1:0]        dut_rvalid;

  modport master (
    output in_data, in_valid, in_ch, orig_req, dup_req, rd_req,
    output dut_rdata, dut_rvalid,
    input  in_ready, dut_wdata, dut_wen, dut_ren
  );

  modport slave (
    input  in_data, in_valid, in_ch, orig_req, dup_req, rd_req,
    input  dut_rdata, dut_rvalid,
    output in_ready, dut_wdata, dut_wen, dut_ren
  );
endinterface
`default_nettype wire

// File: rtl/aqed_fc_multichan_monitor_chan_tracker.sv
`default_nettype none
// ============================================================================
// Module      : aqed_fc_multichan_monitor_chan_tracker
// Description : Per-channel occupancy and write/read order tracking.
//   clk, reset, clk_en : clock, sync active-high reset, global enable
//   wr_acc             : a write was accepted into this channel
//   rd_req             : stimulus read request for this channel
//   rvalid             : memory returned read data on this channel
//   ren                : read enable toward the memory (request & not empty)
//   full, empty        : occupancy == DEPTH / occupancy == 0
//   wr_idx, rd_idx     : running write / read-return indices (wrap)
// Revision    : 1.0 - initial release
// ============================================================================
module aqed_fc_multichan_monitor_chan_tracker #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             wr_acc,
  input  logic             rd_req,
  input  logic             rvalid,
  output logic             ren,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] wr_idx,
  output logic [CNT_W-1:0] rd_idx
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] wr_idx_q, wr_idx_d;
  logic [CNT_W-1:0] rd_idx_q, rd_idx_d;

  assign full   = (occ_q == OCC_W'(DEPTH));
  assign empty  = (occ_q == '0);
  assign ren    = clk_en & ~reset & rd_req & ~empty;
  assign wr_idx = wr_idx_q;
  assign rd_idx = rd_idx_q;

  always_comb begin
    occ_d    = occ_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    // A write and a read in the same cycle cancel out.
    if (wr_acc && !ren) begin
      occ_d = occ_q + 1'b1;
    end else if (!wr_acc && ren) begin
      occ_d = occ_q - 1'b1;
    end
    if (wr_acc) begin
      wr_idx_d = wr_idx_q + 1'b1;
    end
    // Read returns are counted even if unsolicited, so order stays aligned
    // with what the memory actually delivered.
    if (clk_en && rvalid) begin
      rd_idx_d = rd_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q    <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
    end else begin
      occ_q    <= occ_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/aqed_fc_multichan_monitor.sv
`default_nettype none
// ============================================================================
// Module      : aqed_fc_multichan_monitor
// Description : A-QED functional-consistency monitor for FIFO-mode memory
//               cores over NUM_CH channels. Forwards writes, tags one
//               original and one later duplicate write (same data), then
//               compares the two matching read returns.
//   clk, reset, clk_en   : clock, sync active-high reset, global enable
//   bus (slave)          : stimulus and memory-side handshake bundle
//   full, empty          : per-channel back-pressure status
//   qed_state            : FSM state code (debug)
//   qed_done, qed_check  : check finished (sticky) / outputs matched
// Revision    : 1.0 - initial release
// ============================================================================
module aqed_fc_multichan_monitor
  import aqed_fc_multichan_monitor_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = AQED_CNT_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_en,
  aqed_fc_multichan_monitor_if.slave  bus,
  output logic [NUM_CH-1:0]           full,
  output logic [NUM_CH-1:0]           empty,
  output logic [2:0]                  qed_state,
  output logic                        qed_done,
  output logic                        qed_check
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0][CNT_W-1:0] wr_idx;
  logic [NUM_CH-1:0][CNT_W-1:0] rd_idx;
  logic [NUM_CH-1:0]            wen;
  logic [NUM_CH-1:0]            ren;

  logic              sel_full;
  logic [CNT_W-1:0]  sel_wr_idx;
  logic              orig_rvalid, dup_rvalid;
  logic [CNT_W-1:0]  orig_rd_idx, dup_rd_idx;
  logic [DATA_W-1:0] orig_rdata,  dup_rdata;
  logic              wr_acc;
  logic              dup_take;

  logic [2:0]        state_q,     state_d;
  logic [DATA_W-1:0] orig_data_q, orig_data_d;
  logic [CH_W-1:0]   orig_ch_q,   orig_ch_d;
  logic [CNT_W-1:0]  orig_idx_q,  orig_idx_d;
  logic [CH_W-1:0]   dup_ch_q,    dup_ch_d;
  logic [CNT_W-1:0]  dup_idx_q,   dup_idx_d;
  logic [DATA_W-1:0] orig_out_q,  orig_out_d;
  logic [DATA_W-1:0] dup_out_q,   dup_out_d;
  logic              orig_got_q,  orig_got_d;
  logic              dup_got_q,   dup_got_d;

  // Channel muxes. An in_ch beyond NUM_CH reads as full so it is never
  // accepted.
  always_comb begin
    sel_full    = 1'b1;
    sel_wr_idx  = '0;
    orig_rvalid = 1'b0;
    orig_rd_idx = '0;
    orig_rdata  = '0;
    dup_rvalid  = 1'b0;
    dup_rd_idx  = '0;
    dup_rdata   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.in_ch == CH_W'(c)) begin
        sel_full   = full[c];
        sel_wr_idx = wr_idx[c];
      end
      if (orig_ch_q == CH_W'(c)) begin
        orig_rvalid = bus.dut_rvalid[c];
        orig_rd_idx = rd_idx[c];
        orig_rdata  = bus.dut_rdata[c*DATA_W +: DATA_W];
      end
      if (dup_ch_q == CH_W'(c)) begin
        dup_rvalid = bus.dut_rvalid[c];
        dup_rd_idx = rd_idx[c];
        dup_rdata  = bus.dut_rdata[c*DATA_W +: DATA_W];
      end
    end
  end

  assign wr_acc       = clk_en & bus.in_valid & ~sel_full & ~reset;
  assign bus.in_ready = clk_en & ~sel_full & ~reset;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wen[c] = wr_acc & (bus.in_ch == CH_W'(c));
    end
  end

  // The duplicate only counts once an original is held; in IDLE an
  // orig+dup request pair resolves to the original.
  assign dup_take      = wr_acc & bus.dup_req & (state_q == ST_ORIG);
  assign bus.dut_wdata = dup_take ? orig_data_q : bus.in_data;
  assign bus.dut_wen   = wen;
  assign bus.dut_ren   = ren;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    aqed_fc_multichan_monitor_chan_tracker #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
    ) u_trk (
      .clk    (clk),
      .reset  (reset),
      .clk_en (clk_en),
      .wr_acc (wen[c]),
      .rd_req (bus.rd_req[c]),
      .rvalid (bus.dut_rvalid[c]),
      .ren    (ren[c]),
      .full   (full[c]),
      .empty  (empty[c]),
      .wr_idx (wr_idx[c]),
      .rd_idx (rd_idx[c])
    );
  end

  always_comb begin
    state_d     = state_q;
    orig_data_d = orig_data_q;
    orig_ch_d   = orig_ch_q;
    orig_idx_d  = orig_idx_q;
    dup_ch_d    = dup_ch_q;
    dup_idx_d   = dup_idx_q;
    orig_out_d  = orig_out_q;
    dup_out_d   = dup_out_q;
    orig_got_d  = orig_got_q;
    dup_got_d   = dup_got_q;
    if (clk_en) begin
      case (state_q)
        ST_IDLE: begin
          if (wr_acc && bus.orig_req) begin
            state_d     = ST_ORIG;
            orig_data_d = bus.in_data;
            orig_ch_d   = bus.in_ch;
            orig_idx_d  = sel_wr_idx;
          end
        end
        ST_ORIG: begin
          if (dup_take) begin
            state_d   = ST_WAIT;
            dup_ch_d  = bus.in_ch;
            dup_idx_d = sel_wr_idx;
          end
        end
        ST_WAIT: begin
          // The read whose return index equals the tagged write index is
          // the output of that write; both may land in the same cycle.
          if (!orig_got_q && orig_rvalid && (orig_rd_idx == orig_idx_q)) begin
            orig_got_d = 1'b1;
            orig_out_d = orig_rdata;
          end
          if (!dup_got_q && dup_rvalid && (dup_rd_idx == dup_idx_q)) begin
            dup_got_d = 1'b1;
            dup_out_d = dup_rdata;
          end
          if (orig_got_d && dup_got_d) begin
            state_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      orig_data_q <= '0;
      orig_ch_q   <= '0;
      orig_idx_q  <= '0;
      dup_ch_q    <= '0;
      dup_idx_q   <= '0;
      orig_out_q  <= '0;
      dup_out_q   <= '0;
      orig_got_q  <= 1'b0;
      dup_got_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      orig_data_q <= orig_data_d;
      orig_ch_q   <= orig_ch_d;
      orig_idx_q  <= orig_idx_d;
      dup_ch_q    <= dup_ch_d;
      dup_idx_q   <= dup_idx_d;
      orig_out_q  <= orig_out_d;
      dup_out_q   <= dup_out_d;
      orig_got_q  <= orig_got_d;
      dup_got_q   <= dup_got_d;
    end
  end

  assign qed_state = state_q;
  assign qed_done  = (state_q == ST_DONE);
  // Reads as 1 until a verdict exists.
  assign qed_check = (state_q != ST_DONE) | (orig_out_q == dup_out_q);

endmodule
`default_nettype wire

// File: tb/tb_aqed_fc_multichan_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_aqed_fc_multichan_monitor
// Description : Directed bench. u_dut1: one channel, DEPTH 64.
//               u_dut2: two channels, DEPTH 4. Each is backed by a simple
//               in-order FIFO memory model with one cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aqed_fc_multichan_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic clk_en;
  int   checks   = 0;
  int   failures = 0;

  aqed_fc_multichan_monitor_if #(.DATA_W(16), .NUM_CH(1)) bus1 ();
  aqed_fc_multichan_monitor_if #(.DATA_W(16), .NUM_CH(2)) bus2 ();

  logic [0:0] full1, empty1;
  logic [2:0] st1;
  logic       done1, chk1;
  logic [1:0] full2, empty2;
  logic [2:0] st2;
  logic       done2, chk2;

  aqed_fc_multichan_monitor #(.DATA_W(16), .NUM_CH(1), .DEPTH(64), .CNT_W(16)) u_dut1 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .bus(bus1),
    .full(full1), .empty(empty1), .qed_state(st1), .qed_done(done1), .qed_check(chk1)
  );

  aqed_fc_multichan_monitor #(.DATA_W(16), .NUM_CH(2), .DEPTH(4), .CNT_W(16)) u_dut2 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .bus(bus2),
    .full(full2), .empty(empty2), .qed_state(st2), .qed_done(done2), .qed_check(chk2)
  );

  // ---------------- memory models ----------------
  logic [15:0] q1[$];
  logic [15:0] q20[$];
  logic [15:0] q21[$];
  int          rcnt1;
  logic        corrupt1;

  always @(posedge clk) begin : m1
    logic [15:0] d;
    if (reset) begin
      q1.delete();
      rcnt1           <= 0;
      bus1.dut_rvalid <= '0;
      bus1.dut_rdata  <= '0;
    end else begin
      if (bus1.dut_wen[0]) q1.push_back(bus1.dut_wdata);
      bus1.dut_rvalid <= 1'b0;
      if (bus1.dut_ren[0] && q1.size() > 0) begin
        d = q1.pop_front();
        bus1.dut_rdata  <= (corrupt1 && rcnt1 == 4) ? (d ^ 16'h0001) : d;
        bus1.dut_rvalid <= 1'b1;
        rcnt1           <= rcnt1 + 1;
      end
    end
  end

  always @(posedge clk) begin : m2
    logic [15:0] d;
    if (reset) begin
      q20.delete();
      q21.delete();
      bus2.dut_rvalid <= '0;
      bus2.dut_rdata  <= '0;
    end else begin
      if (bus2.dut_wen[0]) q20.push_back(bus2.dut_wdata);
      if (bus2.dut_wen[1]) q21.push_back(bus2.dut_wdata);
      bus2.dut_rvalid <= 2'b00;
      if (bus2.dut_ren[0] && q20.size() > 0) begin
        d = q20.pop_front();
        bus2.dut_rdata[15:0] <= d;
        bus2.dut_rvalid[0]   <= 1'b1;
      end
      if (bus2.dut_ren[1] && q21.size() > 0) begin
        d = q21.pop_front();
        bus2.dut_rdata[31:16] <= d;
        bus2.dut_rvalid[1]    <= 1'b1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus1.in_valid = 1'b0; bus1.orig_req = 1'b0; bus1.dup_req = 1'b0;
    bus1.in_data  = '0;   bus1.in_ch    = '0;   bus1.rd_req  = '0;
    bus2.in_valid = 1'b0; bus2.orig_req = 1'b0; bus2.dup_req = 1'b0;
    bus2.in_data  = '0;   bus2.in_ch    = '0;   bus2.rd_req  = '0;
  endtask

  task automatic pulse_reset();
    idle_all();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  logic [15:0] t1d [5] = '{16'h1111, 16'hA5A5, 16'h2222, 16'h3333, 16'h4444};

  // Five writes, orig on the 2nd, dup on the 5th, then drain.
  task automatic single_ch_run(input logic corrupt, input logic exp_check, input string tag);
    pulse_reset();
    corrupt1 = corrupt;
    for (int i = 0; i < 5; i++) begin
      bus1.in_valid = 1'b1;
      bus1.in_data  = t1d[i];
      bus1.orig_req = (i == 1);
      bus1.dup_req  = (i == 4);
      #1;
      if (i == 4) begin
        chk({tag, "_dup_wdata"}, bus1.dut_wdata, 32'hA5A5);
        chk({tag, "_dup_wen"}, bus1.dut_wen, 32'h1);
      end
      step();
      if (i == 1) chk({tag, "_state_orig"}, st1, 32'd1);
    end
    idle_all();
    chk({tag, "_state_wait"}, st1, 32'd2);
    bus1.rd_req = 1'b1;
    for (int k = 0; k < 20 && !done1; k++) step();
    bus1.rd_req = 1'b0;
    chk({tag, "_done"}, done1, 32'd1);
    chk({tag, "_check"}, chk1, {31'd0, exp_check});
    chk({tag, "_state_done"}, st1, 32'd3);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle_all();
    corrupt1 = 1'b0;
    clk_en   = 1'b1;
    reset    = 1'b1;
    bus1.in_valid = 1'b1;
    step();
    step();
    // Reset state.
    chk("rst_in_ready", bus1.in_ready, 32'd0);
    chk("rst_wen", bus1.dut_wen, 32'd0);
    chk("rst_empty1", empty1, 32'd1);
    chk("rst_full1", full1, 32'd0);
    chk("rst_done", done1, 32'd0);
    chk("rst_check", chk1, 32'd1);
    chk("rst_state", st1, 32'd0);
    chk("rst_empty2", empty2, 32'h3);
    reset = 1'b0;
    idle_all();

    // Matching outputs, then a corrupted duplicate read.
    single_ch_run(1'b0, 1'b1, "t1");
    single_ch_run(1'b1, 1'b0, "t2");
    corrupt1 = 1'b0;

    // DEPTH=4 back-pressure on ch0.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      bus2.in_valid = 1'b1;
      bus2.in_ch    = 1'b0;
      bus2.in_data  = 16'(i + 1);
      step();
    end
    #1;
    chk("t3_full", full2, 32'h1);
    chk("t3_in_ready_full", bus2.in_ready, 32'd0);
    chk("t3_wen_blocked", bus2.dut_wen, 32'd0);
    chk("t3_empty", empty2, 32'h2);
    bus2.in_ch = 1'b1;
    #1;
    chk("t3_in_ready_other", bus2.in_ready, 32'd1);
    bus2.in_valid = 1'b0;
    bus2.in_ch    = 1'b0;
    step();
    chk("t3_full_held", full2, 32'h1);
    // Read while full: write still refused, one entry leaves.
    bus2.in_valid = 1'b1;
    bus2.rd_req   = 2'b01;
    #1;
    chk("t3_ren_full", bus2.dut_ren, 32'h1);
    chk("t3_wen_full", bus2.dut_wen, 32'h0);
    step();
    chk("t3_after_read", full2, 32'h0);
    // Simultaneous read and write: occupancy stays at 3.
    #1;
    chk("t3_rw_wen", bus2.dut_wen, 32'h1);
    chk("t3_rw_ren", bus2.dut_ren, 32'h1);
    step();
    chk("t3_rw_occ_not_full", full2, 32'h0);
    bus2.rd_req = 2'b00;
    step();
    bus2.in_valid = 1'b0;
    chk("t3_rw_occ_refill", full2, 32'h1);

    // Orig on ch0, dup on ch1, ch1 drained first.
    pulse_reset();
    bus2.in_valid = 1'b1; bus2.in_ch = 1'b0; bus2.in_data = 16'h1234; bus2.orig_req = 1'b1;
    step();
    chk("t4_state_orig", st2, 32'd1);
    bus2.in_ch = 1'b1; bus2.in_data = 16'h9999; bus2.orig_req = 1'b0; bus2.dup_req = 1'b1;
    #1;
    chk("t4_dup_wdata", bus2.dut_wdata, 32'h1234);
    chk("t4_dup_wen", bus2.dut_wen, 32'h2);
    step();
    chk("t4_state_wait", st2, 32'd2);
    idle_all();
    bus2.rd_req = 2'b10;
    step();
    bus2.rd_req = 2'b00;
    step();
    step();
    chk("t4_dup_first_wait", st2, 32'd2);
    chk("t4_dup_first_done", done2, 32'd0);
    bus2.rd_req = 2'b01;
    for (int k = 0; k < 20 && !done2; k++) step();
    bus2.rd_req = 2'b00;
    chk("t4_done", done2, 32'd1);
    chk("t4_check", chk2, 32'd1);

    // Tag priority, clk_en hold, dup in IDLE.
    pulse_reset();
    clk_en = 1'b0;
    bus2.in_valid = 1'b1; bus2.in_ch = 1'b0; bus2.in_data = 16'h0F0F; bus2.orig_req = 1'b1;
    #1;
    chk("t5_clken_ready", bus2.in_ready, 32'd0);
    chk("t5_clken_wen", bus2.dut_wen, 32'd0);
    step();
    chk("t5_clken_state", st2, 32'd0);
    chk("t5_clken_empty", empty2, 32'h3);
    clk_en = 1'b1;
    bus2.dup_req = 1'b1;
    #1;
    chk("t5_both_wdata", bus2.dut_wdata, 32'h0F0F);
    step();
    chk("t5_both_state", st2, 32'd1);
    bus2.orig_req = 1'b0; bus2.in_ch = 1'b1; bus2.in_data = 16'h7777;
    step();
    chk("t5_later_dup_state", st2, 32'd2);
    pulse_reset();
    bus2.in_valid = 1'b1; bus2.in_ch = 1'b0; bus2.in_data = 16'h3C3C; bus2.dup_req = 1'b1;
    #1;
    chk("t5_idle_dup_wdata", bus2.dut_wdata, 32'h3C3C);
    step();
    chk("t5_idle_dup_state", st2, 32'd0);
    idle_all();

    // Reset while waiting, after the original has been captured.
    pulse_reset();
    bus2.in_valid = 1'b1; bus2.in_ch = 1'b0;
    bus2.in_data = 16'h5555; bus2.orig_req = 1'b1;
    step();
    bus2.in_data = 16'h6666; bus2.orig_req = 1'b0;
    step();
    bus2.in_data = 16'h7777; bus2.dup_req = 1'b1;
    step();
    idle_all();
    chk("t6_state_wait", st2, 32'd2);
    bus2.rd_req = 2'b01;
    step();
    bus2.rd_req = 2'b00;
    step();
    step();
    chk("t6_still_wait", st2, 32'd2);
    reset = 1'b1;
    step();
    chk("t6_rst_state", st2, 32'd0);
    chk("t6_rst_done", done2, 32'd0);
    chk("t6_rst_empty", empty2, 32'h3);
    chk("t6_rst_full", full2, 32'h0);
    reset = 1'b0;
    #1;
    chk("t6_ready_after", bus2.in_ready, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
